uart_receiver: RTL and testbench

//  SoC-side UART receive core: samples an asynchronous serial line (8N1, LSB first) and delivers bytes over valid/ready.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_receiver.sv | 174 +++++++++++++++++
 tb/tb_uart_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings and
// the clock-divider calculation used by the receiver (and later the transmitter).
package uart_pkg;

    localparam int DEFAULT_BAUD_RATE  = 115_200;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clocks-per-oversample-tick
    function automatic int uart_divider(input int clock_freq, input int baud, input int oversample);
        longint tick_rate;
        tick_rate = longint'(baud) * longint'(oversample);
        return int'((longint'(clock_freq) + tick_rate / 2) / tick_rate);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIVIDER clocks, restartable
// so the receiver can phase-align sampling to a start edge.
module uart_baud_tick #(
    parameter int DIVIDER = 10
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DIVIDER - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_reg <= '0;
        end else if (i_clear || count_reg == COUNT_LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign o_tick = (count_reg == COUNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: 16x oversampled, 3-sample majority vote per bit,
// valid/ready holding register with framing-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_error,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int DIVIDER = uart_divider(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_VOTE0  = SW'(M - 1);
    localparam logic [SW-1:0] S_VOTE1  = SW'(M);
    localparam logic [SW-1:0] S_DECIDE = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if (DIVIDER < 1) begin : g_bad_divider
        $error("uart_receiver: clock too slow for BAUD_RATE*OVERSAMPLE (DIVIDER < 1)");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_receiver: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_receiver: DATA_BITS must be 5..9");
    end

    logic                 rx_meta_reg, rx_sync_reg;
    rx_state_t            state_reg, state_next;
    logic [SW-1:0]        sample_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [1:0]           vote_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg, frame_error_reg, overrun_reg;

    logic tick, clear, decide, bit_close, bit_value, deliver, frame_err;

    uart_baud_tick #(.DIVIDER(DIVIDER)) u_baud_tick (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (clear),
        .o_tick    (tick)
    );

    // Third vote is the live sample, so the decision lands on the M+1 tick itself
    assign decide    = tick && (sample_reg == S_DECIDE);
    assign bit_close = tick && (sample_reg == S_LAST);
    assign bit_value = (vote_reg[0] & vote_reg[1]) | (vote_reg[0] & rx_sync_reg) |
                       (vote_reg[1] & rx_sync_reg);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            state_reg   <= IDLE;
        end else begin
            rx_meta_reg <= i_uart_rx;
            rx_sync_reg <= rx_meta_reg;
            state_reg   <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        deliver    = 1'b0;
        frame_err  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_sync_reg) begin
                    state_next = START;
                    clear      = 1'b1;
                end
            end
            START: begin
                if (decide && bit_value) begin
                    state_next = IDLE;
                end else if (bit_close) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_close && bit_cnt_reg == BIT_LAST) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at stop mid-point to leave resync margin for the next start edge
                if (decide) begin
                    if (bit_value) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sample_reg  <= '0;
            bit_cnt_reg <= '0;
            vote_reg    <= 2'b11;
            shift_reg   <= '0;
        end else begin
            if (clear) begin
                sample_reg <= '0;
            end else if (tick) begin
                sample_reg <= (sample_reg == S_LAST) ? '0 : sample_reg + 1'b1;
            end
            if (tick && sample_reg == S_VOTE0) vote_reg[0] <= rx_sync_reg;
            if (tick && sample_reg == S_VOTE1) vote_reg[1] <= rx_sync_reg;
            if (state_reg != DATA) begin
                bit_cnt_reg <= '0;
            end else if (bit_close) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            if (state_reg == DATA && decide) begin
                shift_reg <= {bit_value, shift_reg[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register: a consume and a new load in the same cycle keeps o_valid high
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_reg        <= '0;
            valid_reg       <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_error_reg <= frame_err;
            overrun_reg     <= deliver && valid_reg && !i_ready;
            if (deliver && (!valid_reg || i_ready)) begin
                data_reg  <= shift_reg;
                valid_reg <= 1'b1;
            end else if (valid_reg && i_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign o_data        = data_reg;
    assign o_valid       = valid_reg;
    assign o_frame_error = frame_error_reg;
    assign o_overrun     = overrun_reg;
    assign o_busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 160 clocks/bit: stimulus pushes expected
// bytes, a negedge monitor pops them on each valid/ready handshake.
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_error;
    logic       o_overrun;
    logic       o_busy;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int fe_cycles = 0;
    int ov_cycles = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLOCK_FREQ (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_uart_rx     (rx),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_frame_error (o_frame_error),
        .o_overrun     (o_overrun),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid)       valid_cycles++;
            if (o_frame_error) fe_cycles++;
            if (o_overrun)     ov_cycles++;
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h expected none", o_data);
                end else begin
                    logic [7:0] exp_byte;
                    exp_byte = exp_q.pop_front();
                    if (o_data !== exp_byte) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h expected %02h", o_data, exp_byte);
                    end else begin
                        $display("rx byte: got %02h expected %02h ok", o_data, exp_byte);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: got %0h ok", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // spike: pull the line low for one tick (10 clocks) inside the bit
    task automatic drive_bit(input logic value, input int period, input bit spike);
        for (int c = 0; c < period; c++) begin
            rx = (spike && c >= 85 && c < 95) ? 1'b0 : value;
            step(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int period, input int spike_bit);
        drive_bit(1'b0, period, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(data[i], period, (i == spike_bit));
        end
        drive_bit(stop_bit, period, 1'b0);
        rx = 1'b1;
    endtask

    initial begin
        int v0, f0, o0;
        rst_n   = 1'b0;
        rx      = 1'b1;
        i_ready = 1'b1;
        step(5);
        check("reset_data", o_data, 0);
        check("reset_valid", o_valid, 0);
        check("reset_frame_error", o_frame_error, 0);
        check("reset_overrun", o_overrun, 0);
        check("reset_busy", o_busy, 0);
        rst_n = 1'b1;
        step(20);

        // 1: plain frame, ready high
        v0 = valid_cycles; f0 = fe_cycles; o0 = ov_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 160, -1);
        check("t1_busy_after_stop", o_busy, 0);
        step(200);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_frame_error", fe_cycles - f0, 0);
        check("t1_overrun", ov_cycles - o0, 0);

        // 2: short start glitch, then a data-bit spike
        v0 = valid_cycles; f0 = fe_cycles;
        rx = 1'b0;
        step(40);
        rx = 1'b1;
        step(40);
        check("t2_busy_in_start", o_busy, 1);
        step(50);
        check("t2_busy_after_reject", o_busy, 0);
        step(100);
        check("t2_glitch_valid", valid_cycles - v0, 0);
        check("t2_glitch_frame_error", fe_cycles - f0, 0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 160, 3);
        step(200);

        // 3: framing error followed by a long break, then recovery
        v0 = valid_cycles; f0 = fe_cycles;
        send_frame(8'h3C, 1'b0, 160, -1);
        rx = 1'b0;
        step(20 * 160);
        check("t3_frame_error_pulses", fe_cycles - f0, 1);
        check("t3_no_valid", valid_cycles - v0, 0);
        rx = 1'b1;
        step(320);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 160, -1);
        step(200);
        check("t3_frame_error_total", fe_cycles - f0, 1);

        // 4: overrun with consumer stalled
        i_ready = 1'b0;
        o0 = ov_cycles;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 160, -1);
        send_frame(8'h02, 1'b1, 160, -1);
        step(200);
        check("t4_overrun_pulses", ov_cycles - o0, 1);
        check("t4_held_data", o_data, 8'h01);
        check("t4_held_valid", o_valid, 1);
        i_ready = 1'b1;
        step(1);
        check("t4_valid_dropped", o_valid, 0);
        step(100);

        // 5: reset mid-frame with a byte pending
        i_ready = 1'b0;
        send_frame(8'h77, 1'b1, 160, -1);
        step(100);
        check("t5_pending_valid", o_valid, 1);
        f0 = fe_cycles; o0 = ov_cycles;
        for (int b = 0; b < 5; b++) drive_bit(1'b0, 160, 1'b0);
        drive_bit(1'b0, 80, 1'b0);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("t5_reset_valid", o_valid, 0);
        check("t5_reset_data", o_data, 0);
        check("t5_reset_busy", o_busy, 0);
        step(3);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        step(50);
        check("t5_no_flags", (fe_cycles - f0) + (ov_cycles - o0), 0);
        check("t5_valid_after_release", o_valid, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 160, -1);
        step(200);

        // 6: sender bit period off by +/-3%
        f0 = fe_cycles; o0 = ov_cycles;
        for (int p = 0; p < 2; p++) begin
            int period;
            period = (p == 0) ? 165 : 155;
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h55);
            exp_q.push_back(8'hFF);
            send_frame(8'h00, 1'b1, period, -1);
            send_frame(8'h55, 1'b1, period, -1);
            send_frame(8'hFF, 1'b1, period, -1);
            step(300);
        end
        check("t6_frame_error", fe_cycles - f0, 0);
        check("t6_overrun", ov_cycles - o0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
